seg_scan_driver: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode seven-segment display on the stopwatch board. It consumes the BCD minutes/seconds digits and the display-rate and blink-rate enable pulses from the stopwatch datapath and clock divider. It scans one digit per display tick, with a blanking guard between digits, frame-coherent digit snapshots and adjust-mode blinking of the selected field. It is the display-side reader of the stopwatch counter outputs.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/bcd_to_seg.sv | 16 +
 rtl/seg_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg_scan_driver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// All patterns are active-low: bit order is g..a, with dp above them.
package seg_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_0000
  };

  // Slot 0 is the leftmost digit, which is driven by an[3].
  localparam logic [3:0] AN_OFF       = 4'b1111;
  localparam logic [3:0] AN_SLOT [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [1:0] DP_SLOT      = 2'd1;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not digits and display a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves o_seg unassigned (no latch).
    o_seg = SEG_DASH;
    if (i_bcd <= 4'd9) o_seg = SEG_DIGITS[i_bcd];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed display scanner with anti-ghost guard, per-frame digit
// snapshot and adjust-mode blinking of the selected field.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic       blink_tick,
  input  logic       adj,
  input  logic       sel,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int             CNT_W      = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);

  scan_state_e      r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_guard_cnt, w_cnt_nxt;
  logic             r_blink_phase, w_blink_nxt;
  logic [3:0]       r_snap [4];
  logic [3:0]       r_an, w_an_nxt;
  logic [7:0]       r_seg, w_seg_nxt;

  logic [3:0]       w_in [4];
  logic             w_take_snap;
  logic [3:0]       w_digit;
  logic [6:0]       w_pat;
  logic             w_blank;

  always_comb begin
    w_in[0] = min_tens;
    w_in[1] = min_ones;
    w_in[2] = sec_tens;
    w_in[3] = sec_ones;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_guard_cnt;
    w_take_snap = 1'b0;
    case (r_state)
      ST_SHOW: begin
        if (scan_tick) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_take_snap = (r_idx == 2'd3);
          if (GUARD_CYCLES > 0) begin
            w_state_nxt = ST_GUARD;
            w_cnt_nxt   = GUARD_LOAD;
          end
        end
      end
      ST_GUARD: begin
        // Ticks arriving here are dropped; the counter alone ends the guard.
        if (r_guard_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_guard_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_SHOW;
    endcase
  end

  assign w_blink_nxt = adj ? (r_blink_phase ^ blink_tick) : 1'b1;

  // Outputs are built from next-cycle state so the registered display matches it exactly.
  assign w_digit = w_take_snap ? w_in[w_idx_nxt] : r_snap[w_idx_nxt];

  bcd_to_seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_pat)
  );

  assign w_blank = adj && !w_blink_nxt && (sel ? w_idx_nxt[1] : !w_idx_nxt[1]);

  always_comb begin
    w_an_nxt  = AN_SLOT[w_idx_nxt];
    w_seg_nxt = {(w_idx_nxt != DP_SLOT), w_pat};
    if (w_state_nxt == ST_GUARD || w_blank) begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_BLANK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_SHOW;
      r_idx         <= 2'd3;
      r_guard_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_an          <= AN_OFF;
      r_seg         <= SEG_BLANK;
      // NOTE: the snapshot is cleared because it is visible right after reset, not as a habit for storage.
      for (int i = 0; i < 4; i++) r_snap[i] <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_guard_cnt   <= w_cnt_nxt;
      r_blink_phase <= w_blink_nxt;
      r_an          <= w_an_nxt;
      r_seg         <= w_seg_nxt;
      if (w_take_snap) begin
        for (int i = 0; i < 4; i++) r_snap[i] <= w_in[i];
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: two drivers (guard 2 and guard 0) share stimulus; a timing-level
// reference model pushes expected outputs and per-instance monitors pop and compare.
module tb_seg_scan_driver;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    bit         chk_seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, scan_tick, blink_tick, adj, sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] an_g2, an_g0;
  logic [7:0] seg_g2, seg_g0;

  seg_scan_driver #(.GUARD_CYCLES(2)) dut_g2 (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .blink_tick(blink_tick),
    .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .an(an_g2), .seg(seg_g2)
  );

  seg_scan_driver #(.GUARD_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .blink_tick(blink_tick),
    .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .an(an_g0), .seg(seg_g0)
  );

  always #5 clk = ~clk;

  localparam int GV [2] = '{2, 0};

  int     errors = 0;
  int     checks = 0;
  exp_t   q_g2[$];
  exp_t   q_g0[$];

  // Model state: slot index, edge of last accepted tick, blink phase, snapshot.
  int         m_idx   [2];
  longint     m_e     [2];
  bit         m_blink [2];
  logic [3:0] m_snap  [2][4];
  longint     n = 0;

  // Positive-logic lit segments (bit0 = a .. bit6 = g); the display wants the inverse.
  function automatic logic [6:0] lit_segments(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic model_inst(input int k, output exp_t x);
    logic [3:0] onehot;
    bit         in_field;
    if (rst) begin
      m_idx[k]   = 3;
      m_e[k]     = n - 100;
      m_blink[k] = 1'b1;
      for (int j = 0; j < 4; j++) m_snap[k][j] = 4'd0;
      x.an = 4'hF; x.seg = 8'hFF; x.chk_seg = 1'b1;
    end else begin
      if (scan_tick && (n > m_e[k] + GV[k])) begin
        m_idx[k] = (m_idx[k] + 1) % 4;
        if (m_idx[k] == 0) begin
          m_snap[k][0] = min_tens; m_snap[k][1] = min_ones;
          m_snap[k][2] = sec_tens; m_snap[k][3] = sec_ones;
        end
        m_e[k] = n;
      end
      m_blink[k] = adj ? (m_blink[k] ^ blink_tick) : 1'b1;
      in_field   = sel ? (m_idx[k] >= 2) : (m_idx[k] < 2);
      if (n - m_e[k] < GV[k]) begin
        x.an = 4'hF; x.seg = 8'hFF; x.chk_seg = 1'b0;
      end else if (adj && !m_blink[k] && in_field) begin
        x.an = 4'hF; x.seg = 8'hFF; x.chk_seg = 1'b1;
      end else begin
        onehot    = 4'b1000 >> m_idx[k];
        x.an      = ~onehot;
        x.seg     = {(m_idx[k] != 1), ~lit_segments(m_snap[k][m_idx[k]])};
        x.chk_seg = 1'b1;
      end
    end
  endtask

  task automatic step();
    exp_t x;
    model_inst(0, x); q_g2.push_back(x);
    model_inst(1, x); q_g0.push_back(x);
    n++;
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint cyc, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  initial begin : mon_g2
    exp_t   x;
    longint c = 0;
    forever begin
      @(posedge clk); #1;
      if (q_g2.size() > 0) begin
        x = q_g2.pop_front();
        check("an_g2", c, {4'h0, an_g2}, {4'h0, x.an});
        if (x.chk_seg) check("seg_g2", c, seg_g2, x.seg);
      end
      c++;
    end
  end

  initial begin : mon_g0
    exp_t   x;
    longint c = 0;
    forever begin
      @(posedge clk); #1;
      if (q_g0.size() > 0) begin
        x = q_g0.pop_front();
        check("an_g0", c, {4'h0, an_g0}, {4'h0, x.an});
        if (x.chk_seg) check("seg_g0", c, seg_g0, x.seg);
      end
      c++;
    end
  end

  task automatic scan_frame(input int ticks, input int gap);
    for (int i = 0; i < ticks; i++) begin
      scan_tick = 1'b1; step();
      scan_tick = 1'b0;
      repeat (gap) step();
    end
  endtask

  initial begin : stim
    rst = 1'b1; scan_tick = 1'b0; blink_tick = 1'b0; adj = 1'b0; sel = 1'b0;
    min_tens = 4'd0; min_ones = 4'd0; sec_tens = 4'd0; sec_ones = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Digits 1,2,3,4 over one frame.
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    scan_frame(4, 5);

    // sec_ones changes mid-frame; the old value must persist until the wrap.
    scan_frame(2, 5);
    sec_ones = 4'd5;
    scan_frame(6, 5);

    // Ticks held high: those arriving during the guard are dropped.
    scan_tick = 1'b1; repeat (5) step();
    scan_tick = 1'b0; repeat (4) step();

    // Blink seconds field in adjust mode, including a tick coinciding with a scan tick.
    adj = 1'b1; sel = 1'b1;
    blink_tick = 1'b1; step(); blink_tick = 1'b0;
    scan_frame(4, 4);
    blink_tick = 1'b1; scan_tick = 1'b1; step();
    blink_tick = 1'b0; scan_tick = 1'b0;
    repeat (4) step();
    scan_frame(4, 4);
    sel = 1'b0;
    blink_tick = 1'b1; step(); blink_tick = 1'b0;
    scan_frame(4, 4);
    adj = 1'b0;

    // Non-BCD value shows a dash.
    sec_tens = 4'hC;
    scan_frame(8, 4);

    // Reset mid-guard.
    scan_tick = 1'b1; step(); scan_tick = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();
    scan_frame(4, 3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      scan_tick  = ($urandom_range(0, 3) == 0);
      blink_tick = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
      if ($urandom_range(0, 9) == 0) begin
        min_tens = 4'($urandom_range(0, 15)); min_ones = 4'($urandom_range(0, 15));
        sec_tens = 4'($urandom_range(0, 15)); sec_ones = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; scan_tick = 1'b0; blink_tick = 1'b0;
    step();

    for (int i = 0; i < 5 && (q_g2.size() > 0 || q_g0.size() > 0); i++) @(negedge clk);
    if (q_g2.size() > 0 || q_g0.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q_g2.size() + q_g0.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
